// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and constants for the pipeline hazard controller.
`default_nettype none

package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } FwdSel;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } DivState;

  localparam logic [1:0] RESULT_SRC_MEM     = 2'b01;
  localparam int         DIV_CYCLES_DEFAULT = 32;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side hazard signals; master is the pipeline, slave is the hazard unit.
`default_nettype none

interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
();

  logic [4:0]  Rs1D, Rs2D;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE;
  logic        DivE;
  logic [4:0]  RdM, RdW;
  logic        RegWriteM, RegWriteW;

  logic        StallF, StallD, StallE;
  logic        FlushD, FlushE, FlushM;
  FwdSel       ForwardAE, ForwardBE;
  logic        DivBusy;
  logic        DivDone;
  logic [31:0] StallCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE, DivE,
           RdM, RdW, RegWriteM, RegWriteW,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
           ForwardAE, ForwardBE, DivBusy, DivDone, StallCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE, DivE,
           RdM, RdW, RegWriteM, RegWriteW,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
           ForwardAE, ForwardBE, DivBusy, DivDone, StallCount
  );

endinterface

`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: forwarding select for one execute-stage operand; Memory beats Writeback.
`default_nettype none

module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  wire logic [4:0] i_rs_e,
  input  wire logic [4:0] i_rd_m,
  input  wire logic [4:0] i_rd_w,
  input  wire logic       i_reg_write_m,
  input  wire logic       i_reg_write_w,
  output FwdSel           o_fwd
);

  always_comb begin
    o_fwd = FWD_RF;
    if (i_reg_write_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs_e))
      o_fwd = FWD_MEM;
    else if (i_reg_write_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs_e))
      o_fwd = FWD_WB;
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stalls, branch flushes, forwarding selects and a fixed-latency divide sequencer.
`default_nettype none

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  hazard_ctrl_if.slave bus
);

  localparam logic [5:0] c_CNT_LOAD = 6'(DIV_CYCLES - 1);

  DivState     r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_stall_count;

  FwdSel       w_fwd_a, w_fwd_b;
  logic        w_lw_stall;
  logic        w_div_stall;
  logic        w_div_done;

  hazard_fwd_sel u_fwd_a (
    .i_rs_e        (bus.Rs1E),
    .i_rd_m        (bus.RdM),
    .i_rd_w        (bus.RdW),
    .i_reg_write_m (bus.RegWriteM),
    .i_reg_write_w (bus.RegWriteW),
    .o_fwd         (w_fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .i_rs_e        (bus.Rs2E),
    .i_rd_m        (bus.RdM),
    .i_rd_w        (bus.RdW),
    .i_reg_write_m (bus.RegWriteM),
    .i_reg_write_w (bus.RegWriteW),
    .o_fwd         (w_fwd_b)
  );

  // Every hazard term is gated by rst_n so reset forces a clean, flushing pipeline.
  always_comb begin
    w_lw_stall  = rst_n && (bus.ResultSrcE == RESULT_SRC_MEM) && (bus.RdE != 5'd0) &&
                  ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
    w_div_stall = rst_n && (((r_state == DIV_IDLE) && bus.DivE) ||
                            ((r_state == DIV_BUSY) && (r_cnt != 6'd0)));
    w_div_done  = rst_n && (r_state == DIV_BUSY) && (r_cnt == 6'd0);
  end

  always_comb begin
    bus.StallE     = w_div_stall;
    bus.StallF     = w_lw_stall | w_div_stall;
    bus.StallD     = w_lw_stall | w_div_stall;
    bus.FlushM     = !rst_n | w_div_stall;
    bus.FlushE     = !rst_n | ((w_lw_stall | bus.PCSrcE) & !w_div_stall);
    bus.FlushD     = !rst_n | (bus.PCSrcE & !w_div_stall);
    bus.ForwardAE  = rst_n ? w_fwd_a : FWD_RF;
    bus.ForwardBE  = rst_n ? w_fwd_b : FWD_RF;
    bus.DivBusy    = (r_state == DIV_BUSY);
    bus.DivDone    = w_div_done;
    bus.StallCount = r_stall_count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DIV_IDLE;
      r_cnt   <= 6'd0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (bus.DivE) begin
            r_state <= DIV_BUSY;
            r_cnt   <= c_CNT_LOAD;
          end
        end
        DIV_BUSY: begin
          if (r_cnt != 6'd0)
            r_cnt <= r_cnt - 6'd1;
          else
            r_state <= DIV_IDLE;
        end
        default: begin
          r_state <= DIV_IDLE;
          r_cnt   <= 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_count <= 32'd0;
    else if (w_lw_stall | w_div_stall)
      r_stall_count <= r_stall_count + 32'd1;
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl with DIV_CYCLES=4.
`default_nettype none

module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.DIV_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hif.Rs1D = 5'd0; hif.Rs2D = 5'd0;
    hif.Rs1E = 5'd0; hif.Rs2E = 5'd0; hif.RdE = 5'd0;
    hif.ResultSrcE = 2'b00; hif.PCSrcE = 1'b0; hif.DivE = 1'b0;
    hif.RdM = 5'd0; hif.RdW = 5'd0;
    hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
  endtask

  // One divide of DIV_CYCLES=4: four stalled cycles then a DivDone cycle.
  task automatic run_divide(input string tag, input int base_count);
    for (int i = 0; i < 5; i++) begin
      #1;
      check({tag, "_stallE"}, hif.StallE, (i < 4));
      check({tag, "_stallF"}, hif.StallF, (i < 4));
      check({tag, "_flushM"}, hif.FlushM, (i < 4));
      check({tag, "_done"},   hif.DivDone, (i == 4));
      check({tag, "_busy"},   hif.DivBusy, (i > 0));
      next_cycle();
    end
    check({tag, "_count"}, hif.StallCount, base_count + 4);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    idle_inputs();
    // Hazard-looking inputs during reset must be masked.
    hif.Rs1E = 5'd5; hif.RdM = 5'd5; hif.RegWriteM = 1'b1; hif.DivE = 1'b1;
    hif.ResultSrcE = RESULT_SRC_MEM; hif.RdE = 5'd3; hif.Rs1D = 5'd3;
    repeat (3) next_cycle();
    check("rst_flushD", hif.FlushD, 1);
    check("rst_flushE", hif.FlushE, 1);
    check("rst_flushM", hif.FlushM, 1);
    check("rst_stallF", hif.StallF, 0);
    check("rst_stallE", hif.StallE, 0);
    check("rst_fwdA",   hif.ForwardAE, 2'b00);
    check("rst_count",  hif.StallCount, 0);
    check("rst_busy",   hif.DivBusy, 0);
    check("rst_done",   hif.DivDone, 0);

    idle_inputs();
    rst_n = 1'b1;
    #1;
    check("rel_flushD", hif.FlushD, 0);
    check("rel_flushE", hif.FlushE, 0);
    check("rel_flushM", hif.FlushM, 0);

    // Forwarding priority
    hif.Rs1E = 5'd5; hif.Rs2E = 5'd5; hif.RdM = 5'd5; hif.RegWriteM = 1'b1;
    hif.RdW = 5'd5; hif.RegWriteW = 1'b1;
    #1;
    check("fwdA_mem", hif.ForwardAE, 2'b10);
    check("fwdB_mem", hif.ForwardBE, 2'b10);
    hif.RdM = 5'd0;
    #1;
    check("fwdA_wb", hif.ForwardAE, 2'b01);
    hif.RegWriteW = 1'b0;
    #1;
    check("fwdA_nowe", hif.ForwardAE, 2'b00);
    hif.RegWriteW = 1'b1; hif.Rs2E = 5'd0; hif.RdW = 5'd0;
    #1;
    check("fwdB_rf", hif.ForwardBE, 2'b00);
    idle_inputs();
    next_cycle();

    // Load-use
    hif.ResultSrcE = RESULT_SRC_MEM; hif.RdE = 5'd7; hif.Rs2D = 5'd7;
    #1;
    check("lw_stallF", hif.StallF, 1);
    check("lw_stallD", hif.StallD, 1);
    check("lw_flushE", hif.FlushE, 1);
    check("lw_stallE", hif.StallE, 0);
    check("lw_flushD", hif.FlushD, 0);
    next_cycle();
    hif.ResultSrcE = 2'b00; hif.RdE = 5'd0;
    hif.RdM = 5'd7; hif.RegWriteM = 1'b1; hif.Rs2E = 5'd7;
    #1;
    check("lw_release", hif.StallF, 0);
    check("lw_count", hif.StallCount, 1);
    check("lw_fwdB", hif.ForwardBE, 2'b10);
    idle_inputs();
    hif.ResultSrcE = RESULT_SRC_MEM; hif.RdE = 5'd0; hif.Rs2D = 5'd0;
    #1;
    check("lw_x0_stall", hif.StallF, 0);
    check("lw_x0_flushE", hif.FlushE, 0);
    next_cycle();
    idle_inputs();

    // Branch
    hif.PCSrcE = 1'b1;
    #1;
    check("br_flushD", hif.FlushD, 1);
    check("br_flushE", hif.FlushE, 1);
    check("br_stallF", hif.StallF, 0);
    next_cycle();
    hif.PCSrcE = 1'b0;
    #1;
    check("br_count", hif.StallCount, 1);
    check("br_flushD_off", hif.FlushD, 0);

    // Back-to-back divides
    hif.DivE = 1'b1;
    run_divide("div1", 1);
    hif.PCSrcE = 1'b1;
    #1;
    check("div2_pcsrc_flushD", hif.FlushD, 0);
    check("div2_pcsrc_flushE", hif.FlushE, 0);
    hif.PCSrcE = 1'b0;
    run_divide("div2", 5);
    hif.DivE = 1'b0;
    #1;
    check("div_idle_stall", hif.StallF, 0);
    check("div_idle_busy", hif.DivBusy, 0);
    next_cycle();

    // Reset in the middle of a divide
    hif.DivE = 1'b1;
    next_cycle();
    hif.DivE = 1'b0;
    next_cycle();
    check("mid_busy_pre", hif.DivBusy, 1);
    check("mid_count_pre", hif.StallCount, 11);
    rst_n = 1'b0;
    #1;
    check("mid_busy", hif.DivBusy, 0);
    check("mid_stallF", hif.StallF, 0);
    check("mid_flushM", hif.FlushM, 1);
    check("mid_count", hif.StallCount, 0);
    next_cycle();
    rst_n = 1'b1;
    #1;
    check("post_stallF", hif.StallF, 0);
    next_cycle();
    check("post_busy", hif.DivBusy, 0);
    check("post_stallE", hif.StallE, 0);
    check("post_count", hif.StallCount, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
